// File: rtl/roundkey_stream_if.sv
// roundkey_stream_if: key request and round-key stream signals between a DES round engine and the key streamer
interface roundkey_stream_if;
  logic [0:63] user_key;
  logic        encr_decr;
  logic        start;
  logic        key_ready;
  logic [0:47] key_out;
  logic        key_valid;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;
  logic        parity_err;
  modport master (
    output user_key, encr_decr, start, key_ready,
    input  key_out, key_valid, round_idx, busy, done, parity_err
  );
  modport slave (
    input  user_key, encr_decr, start, key_ready,
    output key_out, key_valid, round_idx, busy, done, parity_err
  );
endinterface

// File: rtl/roundkey_stream.sv
// roundkey_stream: serial DES key schedule, one 48-bit round key per handshake; define ROUNDKEY_STREAM_PARITY_EN to reject keys with bad byte parity
module roundkey_stream (
  input logic             clk,
  input logic             rst,
  roundkey_stream_if.slave kif
);
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;
  localparam int pc1_t [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int pc2_t [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  state_t      state;
  logic [0:27] c, d;
  logic        enc;
  logic [3:0]  idx;
  logic        one;
  function automatic logic [0:55] pc1(input logic [0:63] k);
    logic [0:55] r;
    logic [5:0]  j;
    for (int i = 0; i < 56; i++) begin
      j = 6'(pc1_t[i] - 1);
      r[i] = k[j];
    end
    return r;
  endfunction
  function automatic logic [0:47] pc2(input logic [0:55] cd);
    logic [0:47] r;
    logic [5:0]  j;
    for (int i = 0; i < 48; i++) begin
      j = 6'(pc2_t[i] - 1);
      r[i] = cd[j];
    end
    return r;
  endfunction
  function automatic logic [0:27] rot(input logic [0:27] x, input logic left, input logic two);
    return left ? (two ? {x[2:27], x[0:1]} : {x[1:27], x[0]})
                : (two ? {x[26:27], x[0:25]} : {x[27], x[0:26]});
  endfunction
`ifdef ROUNDKEY_STREAM_PARITY_EN
  logic perr;
  function automatic logic bad_parity(input logic [0:63] k);
    logic b;
    b = 1'b0;
    for (int i = 0; i < 8; i++) b |= ~^k[8*i +: 8];
    return b;
  endfunction
  assign kif.parity_err = state == LOAD && perr;
`else
  assign kif.parity_err = 1'b0;
`endif
  assign one           = idx == 4'd0 || idx == 4'd7 || idx == 4'd14;
  assign kif.key_out   = pc2({c, d});
  assign kif.key_valid = state == STREAM;
  assign kif.round_idx = idx;
  assign kif.busy      = state == LOAD || state == STREAM;
  assign kif.done      = state == DONE;
  // sequencer: latch PC1 on start, align to the first key, then step C/D once per accepted key
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      c     <= '0;
      d     <= '0;
      enc   <= 1'b0;
      idx   <= '0;
`ifdef ROUNDKEY_STREAM_PARITY_EN
      perr  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (kif.start) begin
          {c, d} <= pc1(kif.user_key);
          enc    <= kif.encr_decr;
          idx    <= '0;
`ifdef ROUNDKEY_STREAM_PARITY_EN
          perr   <= bad_parity(kif.user_key);
`endif
          state  <= LOAD;
        end
        LOAD: begin
          c <= enc ? rot(c, 1'b1, 1'b0) : c;
          d <= enc ? rot(d, 1'b1, 1'b0) : d;
`ifdef ROUNDKEY_STREAM_PARITY_EN
          state <= perr ? IDLE : STREAM;
`else
          state <= STREAM;
`endif
        end
        STREAM: if (kif.key_ready) begin
          if (idx == 4'd15) state <= DONE;
          else begin
            c   <= rot(c, enc, !one);
            d   <= rot(d, enc, !one);
            idx <= idx + 4'd1;
          end
        end
        DONE: begin
          idx   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_roundkey_stream.sv
// tb_roundkey_stream: directed streams with a queued scoreboard for roundkey_stream
module tb_roundkey_stream;
  typedef struct {
    logic [0:47] key;
    logic [3:0]  idx;
  } exp_t;
`ifdef ROUNDKEY_STREAM_PARITY_EN
  localparam logic [0:63] key_main = 64'h736864736d6e626b;
`else
  localparam logic [0:63] key_main = 64'h736865726c6f636b;
`endif
  localparam logic [0:63] key_other = 64'h0123456789abcdef;
  localparam int pc1_t [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int pc2_t [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;
  exp_t q[$];
  roundkey_stream_if kif();
  roundkey_stream dut (.clk(clk), .rst(rst), .kif(kif));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic logic [0:47] ref_key(input logic [0:63] k, input int r);
    logic [0:55] cd;
    logic [0:47] o;
    logic [0:27] c, d;
    logic [5:0]  j;
    for (int i = 0; i < 56; i++) begin
      j = 6'(pc1_t[i] - 1);
      cd[i] = k[j];
    end
    c = cd[0:27];
    d = cd[28:55];
    for (int i = 1; i <= r; i++)
      for (int s = 0; s < ((i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2); s++) begin
        c = {c[1:27], c[0]};
        d = {d[1:27], d[0]};
      end
    cd = {c, d};
    for (int i = 0; i < 48; i++) begin
      j = 6'(pc2_t[i] - 1);
      o[i] = cd[j];
    end
    return o;
  endfunction
  function automatic logic [0:47] hand_key(input int r);
    case (r)
      1:       return 48'he0be66ce0b2b;
      2:       return 48'he0b67635c5a2;
      3:       return 48'he4d676cc0c47;
      5:       return 48'haed37331d7c9;
      6:       return 48'haf535b9a9423;
      14:      return 48'hd0aeae20f39d;
      15:      return 48'hf0be26f314a3;
      16:      return 48'hf0be262bf356;
      default: return 48'h0;
    endcase
  endfunction
  task automatic start_stream(input logic [0:63] k, input logic enc);
    exp_t e;
    int   r;
    for (int n = 0; n < 16; n++) begin
      r = enc ? n + 1 : 16 - n;
      e.key = (k == key_main && hand_key(r) != 48'h0) ? hand_key(r) : ref_key(k, r);
      e.idx = 4'(n);
      q.push_back(e);
    end
    kif.user_key  = k;
    kif.encr_decr = enc;
    kif.start     = 1'b1;
    @(posedge clk); #1;
    kif.start = 1'b0;
    chk("load busy", 64'(kif.busy), 64'd1);
    chk("load key_valid", 64'(kif.key_valid), 64'd0);
    chk("load parity_err", 64'(kif.parity_err), 64'd0);
    @(posedge clk); #1;
    chk("first key_valid", 64'(kif.key_valid), 64'd1);
    chk("first round_idx", 64'(kif.round_idx), 64'd0);
  endtask
  task automatic wait_idx(input int n);
    for (int i = 0; i < 40 && kif.round_idx != 4'(n); i++) begin
      @(posedge clk); #1;
    end
    chk($sformatf("reach round_idx %0d", n), 64'(kif.round_idx), 64'(n));
  endtask
  task automatic wait_done(input string name);
    for (int i = 0; i < 40 && !kif.done; i++) begin
      @(posedge clk); #1;
    end
    chk({name, " done"}, 64'(kif.done), 64'd1);
    chk({name, " drained"}, 64'(q.size()), 64'd0);
    chk({name, " valid at done"}, 64'(kif.key_valid), 64'd0);
    @(posedge clk); #1;
    chk({name, " done pulse"}, 64'(kif.done), 64'd0);
    chk({name, " idle"}, 64'(kif.busy), 64'd0);
  endtask
  // scoreboard monitor: every accepted key must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && kif.key_valid && kif.key_ready) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected key: got %h at round_idx %0d expected no transfer", kif.key_out, kif.round_idx);
      end else begin
        e = q.pop_front();
        chk($sformatf("key at %0d", e.idx), 64'(kif.key_out), 64'(e.key));
        chk($sformatf("round_idx at %0d", e.idx), 64'(kif.round_idx), 64'(e.idx));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    kif.user_key  = '0;
    kif.encr_decr = 1'b0;
    kif.start     = 1'b0;
    kif.key_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset key_out", 64'(kif.key_out), 64'd0);
    chk("reset key_valid", 64'(kif.key_valid), 64'd0);
    chk("reset round_idx", 64'(kif.round_idx), 64'd0);
    chk("reset busy", 64'(kif.busy), 64'd0);
    chk("reset done", 64'(kif.done), 64'd0);
    chk("reset parity_err", 64'(kif.parity_err), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    start_stream(key_main, 1'b1);
    wait_done("encrypt");
    start_stream(key_main, 1'b0);
    wait_done("decrypt");
    start_stream(key_main, 1'b1);
    wait_idx(4);
    kif.key_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall key_out", 64'(kif.key_out), 64'h0000aed37331d7c9);
      chk("stall round_idx", 64'(kif.round_idx), 64'd4);
      chk("stall key_valid", 64'(kif.key_valid), 64'd1);
    end
    kif.key_ready = 1'b1;
    wait_done("backpressure");
    start_stream(key_main, 1'b1);
    wait_idx(7);
    kif.user_key  = key_other;
    kif.encr_decr = 1'b0;
    kif.start     = 1'b1;
    @(posedge clk); #1;
    kif.start = 1'b0;
    wait_done("start while busy");
    start_stream(key_main, 1'b1);
    wait_idx(9);
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    chk("rst key_valid", 64'(kif.key_valid), 64'd0);
    chk("rst busy", 64'(kif.busy), 64'd0);
    chk("rst round_idx", 64'(kif.round_idx), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    start_stream(key_main, 1'b1);
    wait_done("after reset");
`ifdef ROUNDKEY_STREAM_PARITY_EN
    kif.user_key  = 64'h736865726c6f636b;
    kif.encr_decr = 1'b1;
    kif.start     = 1'b1;
    @(posedge clk); #1;
    kif.start = 1'b0;
    chk("parity_err pulse", 64'(kif.parity_err), 64'd1);
    repeat (4) begin
      @(posedge clk); #1;
      chk("parity_err cleared", 64'(kif.parity_err), 64'd0);
      chk("bad parity no key", 64'(kif.key_valid), 64'd0);
      chk("bad parity no done", 64'(kif.done), 64'd0);
      chk("bad parity idle", 64'(kif.busy), 64'd0);
    end
    start_stream(64'h0101010101010101, 1'b1);
    wait_done("good parity");
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
